// File: rtl/tpu_ctrl_pkg.sv
// Shared command codes, state encodings and error codes for the TPU launch controller.
package tpu_ctrl_pkg;

  localparam logic [6:0] FUNC_WR_A    = 7'd1;
  localparam logic [6:0] FUNC_WR_B    = 7'd2;
  localparam logic [6:0] FUNC_RUN     = 7'd3;
  localparam logic [6:0] FUNC_RD_C    = 7'd4;
  localparam logic [6:0] FUNC_SET_OFS = 7'd5;
  localparam logic [6:0] FUNC_ACK     = 7'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ZERO_DIM = 2'd1;
  localparam logic [1:0] ERR_BUSY_CMD = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Host owns the buffers and may issue commands only while the TPU is not in flight.
  function automatic logic host_owns(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

  // Codes that are real host commands (ACK and undefined codes excluded).
  function automatic logic is_host_cmd(input logic [6:0] f);
    return (f >= FUNC_WR_A) && (f <= FUNC_SET_OFS);
  endfunction

endpackage

// File: rtl/tpu_idx_mux.sv
// Steers the three global-buffer index buses between the host address and the TPU addresses.
module tpu_idx_mux #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 sel_tpu,
  input  logic [ADDR_BITS-1:0] host_index,
  input  logic [ADDR_BITS-1:0] tpu_a_index,
  input  logic [ADDR_BITS-1:0] tpu_b_index,
  input  logic [ADDR_BITS-1:0] tpu_c_index,
  output logic [ADDR_BITS-1:0] a_index,
  output logic [ADDR_BITS-1:0] b_index,
  output logic [ADDR_BITS-1:0] c_index
);

  // Select TPU addresses while it owns the buffers, host address otherwise.
  always_comb begin
    if (sel_tpu) begin
      a_index = tpu_a_index;
      b_index = tpu_b_index;
      c_index = tpu_c_index;
    end else begin
      a_index = host_index;
      b_index = host_index;
      c_index = host_index;
    end
  end

endmodule

// File: rtl/tpu_launch_ctrl.sv
// Host command decoder and launch/run/done handshake for one TPU core.
// Optional watchdog enabled by defining TPU_LAUNCH_WATCHDOG_EN.
module tpu_launch_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDR_BITS      = 12,
  parameter int DIM_BITS       = 8,
  parameter int OFFSET_BITS    = 9,
  parameter int CYC_BITS       = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [6:0]             func,
  input  logic [ADDR_BITS-1:0]   host_index,
  input  logic [OFFSET_BITS-1:0] in_offset,
  input  logic [DIM_BITS-1:0]    in_k,
  input  logic [DIM_BITS-1:0]    in_m,
  input  logic [DIM_BITS-1:0]    in_n,
  output logic                   a_wr_en,
  output logic                   b_wr_en,
  output logic [ADDR_BITS-1:0]   a_index,
  output logic [ADDR_BITS-1:0]   b_index,
  output logic [ADDR_BITS-1:0]   c_index,
  input  logic [ADDR_BITS-1:0]   tpu_a_index,
  input  logic [ADDR_BITS-1:0]   tpu_b_index,
  input  logic [ADDR_BITS-1:0]   tpu_c_index,
  output logic                   tpu_in_valid,
  input  logic                   tpu_busy,
  output logic [DIM_BITS-1:0]    tpu_k,
  output logic [DIM_BITS-1:0]    tpu_m,
  output logic [DIM_BITS-1:0]    tpu_n,
  output logic [OFFSET_BITS-1:0] tpu_offset,
  output logic [1:0]             state,
  output logic                   done,
  output logic [1:0]             err,
  output logic [CYC_BITS-1:0]    run_cycles
);

  localparam logic [CYC_BITS-1:0] CYC_MAX = {CYC_BITS{1'b1}};
  localparam logic [CYC_BITS-1:0] CYC_ONE = {{(CYC_BITS-1){1'b0}}, 1'b1};
  localparam logic [DIM_BITS-1:0] DIM_ZERO = {DIM_BITS{1'b0}};

  state_t state_r;
  logic   host_owns_s;
  logic   zero_dim_s;
  logic   busy_cmd_s;

`ifdef TPU_LAUNCH_WATCHDOG_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_BITS-1:0] WD_ONE  = {{(WD_BITS-1){1'b0}}, 1'b1};
  logic [WD_BITS-1:0] wd_cnt_r;
`endif

  assign state = state_r;

  // Command qualification and host write strobes, valid in the cycle of the command.
  always_comb begin
    host_owns_s = host_owns(state_r);
    zero_dim_s  = (in_k == DIM_ZERO) || (in_m == DIM_ZERO) || (in_n == DIM_ZERO);
    busy_cmd_s  = cmd_valid && is_host_cmd(func);
    a_wr_en     = cmd_valid && (func == FUNC_WR_A) && host_owns_s;
    b_wr_en     = cmd_valid && (func == FUNC_WR_B) && host_owns_s;
  end

  tpu_idx_mux #(.ADDR_BITS(ADDR_BITS)) u_idx_mux (
    .sel_tpu     (!host_owns_s),
    .host_index  (host_index),
    .tpu_a_index (tpu_a_index),
    .tpu_b_index (tpu_b_index),
    .tpu_c_index (tpu_c_index),
    .a_index     (a_index),
    .b_index     (b_index),
    .c_index     (c_index)
  );

  // Launch/run/done state machine with all registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      tpu_in_valid <= 1'b0;
      done         <= 1'b0;
      err          <= ERR_NONE;
      run_cycles   <= {CYC_BITS{1'b0}};
      tpu_k        <= DIM_ZERO;
      tpu_m        <= DIM_ZERO;
      tpu_n        <= DIM_ZERO;
      tpu_offset   <= {OFFSET_BITS{1'b0}};
`ifdef TPU_LAUNCH_WATCHDOG_EN
      wd_cnt_r     <= {WD_BITS{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (cmd_valid) begin
            case (func)
              FUNC_SET_OFS: tpu_offset <= in_offset;
              FUNC_RUN: begin
                if (zero_dim_s) begin
                  err <= ERR_ZERO_DIM;
                end else begin
                  tpu_k        <= in_k;
                  tpu_m        <= in_m;
                  tpu_n        <= in_n;
                  err          <= ERR_NONE;
                  done         <= 1'b0;
                  run_cycles   <= {CYC_BITS{1'b0}};
                  tpu_in_valid <= 1'b1;
                  state_r      <= ST_LAUNCH;
`ifdef TPU_LAUNCH_WATCHDOG_EN
                  wd_cnt_r     <= {WD_BITS{1'b0}};
`endif
                end
              end
              FUNC_ACK: begin
                if (state_r == ST_DONE) begin
                  state_r <= ST_IDLE;
                  done    <= 1'b0;
                end
              end
              default: begin
              end
            endcase
          end
        end
        ST_LAUNCH: begin
          if (busy_cmd_s) err <= ERR_BUSY_CMD;
          if (tpu_busy) begin
            tpu_in_valid <= 1'b0;
            state_r      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (busy_cmd_s) err <= ERR_BUSY_CMD;
          if (run_cycles != CYC_MAX) run_cycles <= run_cycles + CYC_ONE;
          if (!tpu_busy) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
`ifdef TPU_LAUNCH_WATCHDOG_EN
      // Watchdog overrides the handshake once the in-flight budget is used up.
      if (!host_owns_s) begin
        if (wd_cnt_r == WD_LAST) begin
          state_r      <= ST_DONE;
          done         <= 1'b1;
          err          <= ERR_TIMEOUT;
          tpu_in_valid <= 1'b0;
        end else begin
          wd_cnt_r <= wd_cnt_r + WD_ONE;
        end
      end
`endif
    end
  end

endmodule

// File: doc/tpu_launch_ctrl.md
Name: tpu_launch_ctrl

Overview:
Host-side command controller that sits between the host function interface and one TPU core plus its A/B/C global buffers. It decodes host commands, steers the shared buffer index buses between host and TPU, and latches the offset and dimensions. It runs a launch/run/done handshake with the TPU and reports status, error and cycle count. It is the parametrised, fully synchronous successor of the earlier negedge launch pattern.

Parameters:
ADDR_BITS, 12, index width of all global buffers
DIM_BITS, 8, width of K/M/N
OFFSET_BITS, 9, width of InputOffset
CYC_BITS, 32, width of run-cycle counter
TIMEOUT_CYCLES, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  single-cycle command strobe
func  in  7  command code: 1=WR_A, 2=WR_B, 3=RUN, 4=RD_C, 5=SET_OFS, 6=ACK
host_index  in  ADDR_BITS  host buffer address
in_offset  in  OFFSET_BITS  InputOffset for SET_OFS
in_k / in_m / in_n  in  DIM_BITS each  dimensions for RUN
a_wr_en / b_wr_en  out  1  buffer write enables
a_index / b_index / c_index  out  ADDR_BITS  muxed buffer addresses
tpu_a_index / tpu_b_index / tpu_c_index  in  ADDR_BITS  TPU-driven addresses
tpu_in_valid  out  1  launch strobe to TPU
tpu_busy  in  1  TPU busy
tpu_k / tpu_m / tpu_n  out  DIM_BITS  latched dimensions
tpu_offset  out  OFFSET_BITS  latched offset
state  out  2  0=IDLE 1=LAUNCH 2=RUN 3=DONE
done  out  1  high in DONE
err  out  2  0=none 1=zero-dim 2=cmd-while-busy 3=timeout
run_cycles  out  CYC_BITS  cycles spent in RUN, saturating

Behaviour:
- Reset: state=IDLE; tpu_in_valid=0; done=0; err=0; run_cycles=0; tpu_k/m/n=0; tpu_offset=0; write enables=0.
- All outputs are registered except a_wr_en, b_wr_en and the index muxes, which are combinational.
- a_wr_en = cmd_valid & func==1 & state∈{IDLE,DONE}. b_wr_en is the same with func==2.
- Index mux: state∈{LAUNCH,RUN} selects the tpu_* indices; otherwise all three indices = host_index.
- SET_OFS in IDLE/DONE: tpu_offset <= in_offset on the next edge.
- RUN in IDLE or DONE:
  - If any of in_k/in_m/in_n is 0: err<=1, state unchanged, no launch.
  - Otherwise: latch dims, err<=0, done<=0, run_cycles<=0, tpu_in_valid<=1, state<=LAUNCH.
- LAUNCH: hold tpu_in_valid=1 until tpu_busy sampled high. Then tpu_in_valid<=0 and state<=RUN on that same edge.
- RUN: run_cycles increments each cycle, saturating at all-ones. On tpu_busy sampled low: state<=DONE, done<=1.
- DONE: holds until ACK (→IDLE, done<=0, err and run_cycles retained) or a new RUN (relaunch directly).
- Any command other than ACK received in LAUNCH/RUN: ignored, err<=2, no write enable. ACK in LAUNCH/RUN: ignored, no error.
- func codes 0 and 7..127: no-op in every state.
- RD_C: no state change. It only guarantees c_index=host_index; data comes from the buffer with 1-cycle latency.
- Reset mid-operation returns to IDLE within one edge and drops tpu_in_valid.
- Launch latency: tpu_in_valid asserts 1 cycle after the RUN strobe.

Optional Feature:
TPU_LAUNCH_WATCHDOG_EN.
- Defined: a counter runs in LAUNCH and RUN. On reaching TIMEOUT_CYCLES it forces state<=DONE, done<=1, err<=3 and tpu_in_valid<=0. The counter clears on entering LAUNCH.
- Undefined: no watchdog logic. err value 3 is never produced, and the controller waits indefinitely.

Decomposition:
- Shared package tpu_ctrl_pkg: func code constants (FUNC_WR_A..FUNC_ACK), state encodings (ST_IDLE..ST_DONE), err code constants.
- One natural sub-module: tpu_idx_mux, the combinational host/TPU selection of the three index buses.

Test Plan:
1. Reset, then WR_A at host_index=0x010 → a_wr_en high that cycle, a_index=0x010, b_wr_en=0.
2. SET_OFS in_offset=0x080, then RUN K=4 M=4 N=4 → tpu_offset=0x080, tpu_in_valid high next cycle. Then:
   - TPU raises busy 2 cycles later → state=RUN, in_valid low.
   - busy held 10 cycles → DONE with run_cycles=10.
3. RUN with K=0 → err=1, state stays IDLE, tpu_in_valid never asserts.
4. WR_B issued during RUN → b_wr_en stays 0, err=2, b_index follows tpu_b_index.
5. In DONE, ACK → state=IDLE, done=0. A new RUN in DONE relaunches without ACK.
6. With TPU_LAUNCH_WATCHDOG_EN and TIMEOUT_CYCLES=16, tpu_busy never asserted → DONE at cycle 16, err=3. Assert reset mid-RUN → IDLE next edge.
